// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier with signed/unsigned select.
// Retires one Booth digit per clock; WIDTH/2+1 digits per product.
module booth_mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned NDig = WIDTH / 2 + 1;
   localparam int unsigned ExtW = WIDTH + 2;
   localparam int unsigned AccW = 2 * WIDTH + 4;
   localparam int unsigned CntW = $clog2(NDig);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q, state_d;
   logic [ExtW-1:0]        a_q, a_d;
   // Extended multiplier with the implicit 0 below bit 0; shifted right two bits per digit
   logic [ExtW:0]          m_q, m_d;
   logic [AccW-1:0]        acc_q, acc_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     res_q, res_d;

   logic                   capture;
   logic                   last_digit;
   logic                   a_sx, b_sx;
   logic [ExtW-1:0]        pp;
   logic [AccW-1:0]        pp_ext;
   logic [CntW:0]          shamt;
   logic [AccW-1:0]        acc_sum;

   assign capture    = start && ((state_q == StIdle) || (state_q == StDone));
   assign last_digit = (cnt_q == CntW'(NDig - 1));
   assign a_sx       = is_signed & a[WIDTH-1];
   assign b_sx       = is_signed & b[WIDTH-1];

   // Partial product selected by the current Booth triple, at WIDTH+2 bits
   always_comb begin
      pp = '0;
      unique case (m_q[2:0])
         3'b001, 3'b010: pp = a_q;
         3'b011:         pp = {a_q[ExtW-2:0], 1'b0};
         3'b100:         pp = -{a_q[ExtW-2:0], 1'b0};
         3'b101, 3'b110: pp = -a_q;
         default:        pp = '0;
      endcase
   end

   // Sign-extend the partial product and align it to digit position 2i
   always_comb begin
      pp_ext  = {{(AccW - ExtW){pp[ExtW-1]}}, pp};
      shamt   = {cnt_q, 1'b0};
      acc_sum = acc_q + (pp_ext << shamt);
   end

   // Next-state logic: capture, digit retirement and result write
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      unique case (state_q)
         StIdle: ;
         StRun: begin
            acc_d = acc_sum;
            m_d   = m_q >> 2;
            cnt_d = cnt_q + 1'b1;
            if (last_digit) begin
               res_d   = acc_sum[2*WIDTH-1:0];
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Capture overrides the IDLE/DONE defaults; never true in RUN
      if (capture) begin
         a_d     = {a_sx, a_sx, a};
         m_d     = {b_sx, b_sx, b, 1'b0};
         acc_d   = '0;
         cnt_d   = '0;
         state_d = StRun;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Outputs decoded straight from registers
   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
      hi   = res_q[2*WIDTH-1:WIDTH];
      lo   = res_q[WIDTH-1:0];
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

   logic        clock;
   logic        reset_n;

   logic        st32, sg32;
   logic [31:0] a32, b32;
   logic        busy32, done32;
   logic [31:0] hi32, lo32;

   logic        st8, sg8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [7:0]  hi8, lo8;

   int checks;
   int errors;

   booth_mult_seq #(.WIDTH(32)) u_dut32 (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (st32),
      .is_signed (sg32),
      .a         (a32),
      .b         (b32),
      .busy      (busy32),
      .done      (done32),
      .hi        (hi32),
      .lo        (lo32)
   );

   booth_mult_seq #(.WIDTH(8)) u_dut8 (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (st8),
      .is_signed (sg8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .hi        (hi8),
      .lo        (lo8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One 32-bit multiply from IDLE: latency, result, single-cycle done
   task automatic run32(input logic sg, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
      int lat;
      lat  = 0;
      st32 = 1'b1; sg32 = sg; a32 = x; b32 = y;
      @(posedge clock); #1;
      // Operands may change after capture
      st32 = 1'b0; sg32 = ~sg; a32 = ~x; b32 = ~y;
      checks++;
      if (busy32 !== 1'b1) begin
         errors++; $display("FAIL %s busy: got %b expected 1", nm, busy32);
      end
      while (done32 !== 1'b1 && lat < 40) begin
         @(posedge clock); #1; lat++;
      end
      checks++;
      if (lat != 17) begin
         errors++; $display("FAIL %s latency: got %0d expected 17", nm, lat);
      end
      checks++;
      if (hi32 !== eh) begin
         errors++; $display("FAIL %s hi: got %h expected %h", nm, hi32, eh);
      end
      checks++;
      if (lo32 !== el) begin
         errors++; $display("FAIL %s lo: got %h expected %h", nm, lo32, el);
      end
      @(posedge clock); #1;
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
         errors++; $display("FAIL %s done_width: got done=%b busy=%b expected 0 0",
                            nm, done32, busy32);
      end
   endtask

   // One 8-bit multiply from IDLE, latency 5
   task automatic run8(input logic sg, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] ep, input string nm);
      int lat;
      lat = 0;
      st8 = 1'b1; sg8 = sg; a8 = x; b8 = y;
      @(posedge clock); #1;
      st8 = 1'b0; sg8 = ~sg; a8 = ~x; b8 = ~y;
      while (done8 !== 1'b1 && lat < 20) begin
         @(posedge clock); #1; lat++;
      end
      checks++;
      if (lat != 5) begin
         errors++; $display("FAIL %s latency: got %0d expected 5", nm, lat);
      end
      checks++;
      if ({hi8, lo8} !== ep) begin
         errors++; $display("FAIL %s product: got %h expected %h", nm, {hi8, lo8}, ep);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
      st8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
      #12;
      checks++;
      if ({busy32, done32, hi32, lo32} !== 66'd0) begin
         errors++; $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h expected zeros",
                            busy32, done32, hi32, lo32);
      end
      checks++;
      if ({busy8, done8, hi8, lo8} !== 18'd0) begin
         errors++; $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h expected zeros",
                            busy8, done8, hi8, lo8);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_mult32();
      run32(1'b1, 32'hFFFFFFFD, 32'd5,       32'hFFFFFFFF, 32'hFFFFFFF1, "s_m3x5");
      run32(1'b0, 32'hFFFFFFFD, 32'd5,       32'h00000004, 32'hFFFFFFF1, "u_fffffffdx5");
      run32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "u_maxsq");
      run32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "s_m1sq");
      run32(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "s_minsq");
      run32(1'b1, 32'h80000000, 32'd1,       32'hFFFFFFFF, 32'h80000000, "s_minx1");
      run32(1'b1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "s_7xm1");
      run32(1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "u_2p16sq");
   endtask

   // Previous result is 1:0; start pulsed mid-RUN must be ignored
   task automatic test_start_ignored();
      int dn;
      int dk;
      dn = 0; dk = 0;
      st32 = 1'b1; sg32 = 1'b1; a32 = 32'hFFFFFFFD; b32 = 32'd5;
      @(posedge clock); #1;
      st32 = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 5) begin
            st32 = 1'b1; sg32 = 1'b0; a32 = 32'd7; b32 = 32'd9;
         end else begin
            st32 = 1'b0;
         end
         @(posedge clock); #1;
         if (k == 10) begin
            checks++;
            if (hi32 !== 32'd1 || lo32 !== 32'd0) begin
               errors++; $display("FAIL hold_in_run: got %h_%h expected 00000001_00000000",
                                  hi32, lo32);
            end
         end
         if (done32 === 1'b1) begin
            dn++;
            if (dk == 0) dk = k;
         end
      end
      checks++;
      if (dn != 1) begin
         errors++; $display("FAIL ignore_start done_count: got %0d expected 1", dn);
      end
      checks++;
      if (dk != 17) begin
         errors++; $display("FAIL ignore_start latency: got %0d expected 17", dk);
      end
      checks++;
      if (hi32 !== 32'hFFFFFFFF || lo32 !== 32'hFFFFFFF1) begin
         errors++; $display("FAIL ignore_start result: got %h_%h expected FFFFFFFF_FFFFFFF1",
                            hi32, lo32);
      end
   endtask

   // Previous result is nonzero; reset at RUN cycle 8 clears everything at once
   task automatic test_reset_mid_run();
      int dn;
      dn = 0;
      st32 = 1'b1; sg32 = 1'b1; a32 = 32'h80000000; b32 = 32'd1;
      @(posedge clock); #1;
      st32 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock); #1;
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
         errors++; $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h expected zeros",
                            busy32, done32, hi32, lo32);
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (done32 === 1'b1) dn++;
      end
      checks++;
      if (dn != 0) begin
         errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", dn);
      end
      run32(1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "after_reset");
   endtask

   task automatic test_width8();
      run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u_ffsq");
      run8(1'b1, 8'hFF, 8'hFF, 16'h0001, "w8_s_m1sq");
      run8(1'b1, 8'h80, 8'h80, 16'h4000, "w8_s_minsq");
      run8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8_s_minxmax");
      run8(1'b0, 8'h80, 8'h7F, 16'h3F80, "w8_u_80x7f");
      run8(1'b0, 8'hAB, 8'h0C, 16'h0804, "w8_u_abx0c");
      run8(1'b1, 8'hAB, 8'h0C, 16'hFC04, "w8_s_abx0c");
      run8(1'b1, 8'h05, 8'hFD, 16'hFFF1, "w8_s_5xm3");
      run8(1'b0, 8'h05, 8'hFD, 16'h04F1, "w8_u_5xfd");
      run8(1'b1, 8'h00, 8'h7B, 16'h0000, "w8_s_zero");
   endtask

   // start held high: captures happen in the DONE cycle, one result per 6 cycles
   task automatic test_back_to_back();
      logic [7:0]  va [3];
      logic [7:0]  vb [3];
      logic        vs [3];
      logic [15:0] vp [3];
      int idx;
      int last_k;
      va[0] = 8'h05; vb[0] = 8'hFD; vs[0] = 1'b1; vp[0] = 16'hFFF1;
      va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 1'b0; vp[1] = 16'hFE01;
      va[2] = 8'h80; vb[2] = 8'h80; vs[2] = 1'b1; vp[2] = 16'h4000;
      idx = 0; last_k = 0;
      st8 = 1'b1; sg8 = vs[0]; a8 = va[0]; b8 = vb[0];
      @(posedge clock); #1;
      for (int k = 1; k <= 40 && idx < 3; k++) begin
         @(posedge clock); #1;
         if (done8 === 1'b1) begin
            checks++;
            if ((k - last_k) != ((idx == 0) ? 5 : 6)) begin
               errors++; $display("FAIL b2b_spacing_%0d: got %0d expected %0d",
                                  idx, k - last_k, (idx == 0) ? 5 : 6);
            end
            checks++;
            if ({hi8, lo8} !== vp[idx]) begin
               errors++; $display("FAIL b2b_product_%0d: got %h expected %h",
                                  idx, {hi8, lo8}, vp[idx]);
            end
            last_k = k;
            idx++;
            if (idx < 3) begin
               sg8 = vs[idx]; a8 = va[idx]; b8 = vb[idx];
            end else begin
               st8 = 1'b0;
            end
         end
      end
      st8 = 1'b0;
      checks++;
      if (idx != 3) begin
         errors++; $display("FAIL b2b_count: got %0d expected 3", idx);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mult32();
      test_start_ignored();
      test_reset_mid_run();
      test_width8();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
